// File: rtl/conv_result_collector_pkg.sv
// Shared definitions for the conv result collector.
//   drain_state_t : which lane the drain FSM is serialising (L0 = lane 0, L1 = lane 1)
//   ROW_W / COL_W : widths of the row/column tags on the output stream
package conv_result_collector_pkg;

  typedef enum logic {
    L0 = 1'b0,
    L1 = 1'b1
  } drain_state_t;

  localparam int unsigned ROW_W = 3;
  localparam int unsigned COL_W = 8;

endpackage

// File: rtl/conv_result_collector_if.sv
// Stream bundle of the conv result collector.
//   in_port0/in_valid0 : lane 0 word (even row of a pair, or the odd last row)
//   in_port1/in_valid1 : lane 1 word (odd row of a pair); no upstream backpressure
//   m_data/m_valid/m_ready : serialised row-major ready/valid output
//   m_row/m_col/m_last     : tags of m_data; m_last marks the final word of a frame
// Modports: slave = collector side, master = producer/consumer side.
interface conv_result_collector_if
  import conv_result_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 25
) ();

  logic [DATA_WIDTH-1:0] in_port0;
  logic [DATA_WIDTH-1:0] in_port1;
  logic                  in_valid0;
  logic                  in_valid1;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [ROW_W-1:0]      m_row;
  logic [COL_W-1:0]      m_col;
  logic                  m_last;

  modport slave (
    input  in_port0, in_port1, in_valid0, in_valid1, m_ready,
    output m_data, m_valid, m_row, m_col, m_last
  );

  modport master (
    output in_port0, in_port1, in_valid0, in_valid1, m_ready,
    input  m_data, m_valid, m_row, m_col, m_last
  );

endinterface

// File: rtl/conv_result_collector_lane_fifo.sv
// result_lane_fifo: first-word-fall-through synchronous FIFO for one result lane.
//   clk, rst_n (async, active-low), flush (sync empty)
//   wr_en/wr_data : write port; a write while full is accepted only if a read
//                   happens in the same cycle, otherwise it is dropped
//   rd_en/rd_data : rd_data always shows the head word; rd_en pops it
//   count         : number of stored words
//   drop          : combinational pulse, a write was dropped this cycle
module result_lane_fifo #(
  parameter  int unsigned DATA_WIDTH = 25,
  parameter  int unsigned FIFO_DEPTH = 64,
  localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [CNT_W-1:0]      count,
  output logic                  drop
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  full;
  logic                  empty;
  logic                  do_wr;
  logic                  do_rd;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign do_rd   = rd_en & ~empty & ~flush;
  // When full, a same-cycle pop frees the slot the write lands in.
  assign do_wr   = wr_en & ~flush & (~full | do_rd);
  assign drop    = wr_en & ~flush & full & ~do_rd;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
      if (do_rd) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/conv_result_collector.sv
// conv_result_collector: receives the dual-lane conv result stream (rows paired
// on lanes 0/1, odd last row on lane 0), buffers each lane and re-serialises it
// into one row-major ready/valid stream tagged with row/col.
//   clk, rst_n      : clock, async active-low reset
//   flush           : sync; empties FIFOs, row/col to 0, state L0 (beats writes/transfers)
//   clear_err       : sync clear of the sticky flags (a same-cycle new error wins)
//   bus (slave)     : lane inputs and serialised output stream
//   frame_done      : 1-cycle pulse the cycle after the m_last transfer
//   overflow        : sticky, a lane write was dropped on a full FIFO
//   proto_err       : sticky, in_valid1 seen without in_valid0
// Build option: define CONV_RELU_EN to zero negative words on m_data.
module conv_result_collector
  import conv_result_collector_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 25,
  parameter int unsigned DEPTH      = 61,
  parameter int unsigned ROWS       = 5,
  parameter int unsigned FIFO_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    clear_err,
  conv_result_collector_if.slave  bus,
  output logic                    frame_done,
  output logic                    overflow,
  output logic                    proto_err
);

  localparam int unsigned      CNT_W    = $clog2(FIFO_DEPTH + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DEPTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  drain_state_t          state, state_nxt;
  logic [ROW_W-1:0]      row, row_nxt;
  logic [COL_W-1:0]      col, col_nxt;
  logic [CNT_W-1:0]      count0, count1;
  logic [DATA_WIDTH-1:0] head0, head1, head, data_out;
  logic                  drop0, drop1;
  logic                  valid_i, xfer, last_i, frame_end, lone_v1;
  logic [ROW_W-1:0]      row_i;

  result_lane_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_lane0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (bus.in_valid0),
    .wr_data (bus.in_port0),
    .rd_en   (xfer && (state == L0)),
    .rd_data (head0),
    .count   (count0),
    .drop    (drop0)
  );

  result_lane_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_lane1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .wr_en   (bus.in_valid1),
    .wr_data (bus.in_port1),
    .rd_en   (xfer && (state == L1)),
    .rd_data (head1),
    .count   (count1),
    .drop    (drop1)
  );

  always_comb begin
    head      = (state == L0) ? head0 : head1;
    valid_i   = (state == L0) ? (count0 != '0) : (count1 != '0);
    row_i     = (state == L0) ? row : row + ROW_W'(1);
    last_i    = valid_i && (col == COL_LAST) && (row_i == ROW_LAST);
    xfer      = valid_i & bus.m_ready & ~flush;

    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    frame_end = 1'b0;

    if (flush) begin
      state_nxt = L0;
      row_nxt   = '0;
      col_nxt   = '0;
    end else if (xfer) begin
      if (col == COL_LAST) begin
        col_nxt = '0;
        if (state == L0) begin
          if (32'(row) + 32'd1 < ROWS) state_nxt = L1;
          else                         frame_end = 1'b1;
        end else begin
          // Even ROWS ends the frame on lane 1; otherwise step to the next pair.
          if (32'(row) + 32'd2 < ROWS) begin
            row_nxt   = row + ROW_W'(2);
            state_nxt = L0;
          end else begin
            frame_end = 1'b1;
          end
        end
        if (frame_end) begin
          row_nxt   = '0;
          state_nxt = L0;
        end
      end else begin
        col_nxt = col + COL_W'(1);
      end
    end
  end

`ifdef CONV_RELU_EN
  assign data_out = head[DATA_WIDTH-1] ? '0 : head;
`else
  assign data_out = head;
`endif

  // Gated so an empty lane never exposes uninitialised storage.
  assign bus.m_data  = valid_i ? data_out : '0;
  assign bus.m_valid = valid_i;
  assign bus.m_row   = row_i;
  assign bus.m_col   = col;
  assign bus.m_last  = last_i;

  assign lone_v1 = bus.in_valid1 & ~bus.in_valid0 & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= L0;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      proto_err  <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (drop0 | drop1)  overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (lone_v1)        proto_err <= 1'b1;
      else if (clear_err) proto_err <= 1'b0;
    end
  end

endmodule
